// File: rtl/sub32_nibble_serial_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master presents operands and consumes results; the slave is the subtractor.
interface sub32_nibble_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, neg, ovf
  );
endinterface

// File: rtl/sub32_nibble_serial.sv
// Area-cheap serial subtractor: one SLICE-bit adder plus a carry flop computes
// a - b - bin over WIDTH/SLICE cycles, with borrow/zero/sign/overflow flags.
module sub32_nibble_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sub32_nibble_serial_if.slave bus
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   a_sh, nb_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb, b_msb;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, zero_q, neg_q, ovf_q;

  logic [SLICE:0]     slice_sum;
  logic [WIDTH-1:0]   diff_next;
  logic               last_slice;

  // Operands shift down so the active slice is always the low SLICE bits;
  // the result shifts in from the top and is complete after N slices.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    slice_sum  = '0;
    diff_next  = diff_q;
    last_slice = 1'b0;
    state_next = state;

    slice_sum  = {1'b0, a_sh[SLICE-1:0]} + {1'b0, nb_sh[SLICE-1:0]}
               + {{SLICE{1'b0}}, carry};
    diff_next  = {slice_sum[SLICE-1:0], diff_q[WIDTH-1:SLICE]};
    last_slice = (cnt == CNT_W'(N - 1));

    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last_slice)    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      nb_sh  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            nb_sh <= ~bus.b;
            carry <= ~bus.bin;
            cnt   <= '0;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
          end
        end
        RUN: begin
          a_sh   <= a_sh >> SLICE;
          nb_sh  <= nb_sh >> SLICE;
          carry  <= slice_sum[SLICE];
          cnt    <= cnt + CNT_W'(1);
          diff_q <= diff_next;
          if (last_slice) begin
            // Carry out of an inverted-subtrahend add is the complement of borrow.
            bout_q <= ~slice_sum[SLICE];
            zero_q <= (diff_next == '0);
            neg_q  <= diff_next[WIDTH-1];
            ovf_q  <= (a_msb != b_msb) && (diff_next[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/sub32_nibble_serial.md
# sub32_nibble_serial

Multi-cycle 32-bit subtractor that processes one 4-bit slice per clock. It models a single 4-bit adder slice, fed with the inverted subtrahend, plus a registered carry/borrow flip-flop, instead of a parallel carry-lookahead tree. It sits beside the parallel 32-bit adder in the ALU datapath as the area-cheap subtract/compare path. Operands enter and results leave through a valid/ready handshake, and flags are produced for the compare logic.

## Interface
- WIDTH, 32, operand width; must be a multiple of SLICE
- SLICE, 4, bits processed per cycle; number of slices N = WIDTH/SLICE (8 by default)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- bin  in  1  borrow in (1 means subtract an extra 1)
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  out  1  borrow out; 1 when a < b + bin (unsigned)
- zero  out  1  diff == 0
- neg  out  1  diff[WIDTH-1]
- ovf  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch a, ~b and carry = ~bin, clear the slice counter, then go to RUN.
  - in_valid while not in IDLE is ignored. Operands are sampled only on the accept edge.
- RUN, one slice k per cycle, k = 0..N-1:
  - {c, s} = a[k*SLICE +: SLICE] + nb[k*SLICE +: SLICE] + carry, computed at SLICE+1 bits wide.
  - Write s into diff[k*SLICE +: SLICE]. Store c as the new carry.
- After slice N-1 is written:
  - bout = ~carry.
  - zero = (diff == 0), evaluated on the full result.
  - neg = diff[WIDTH-1].
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - out_valid=1, and the FSM goes to DONE.
- DONE:
  - diff and all flags hold stable.
  - On out_ready, clear out_valid and return to IDLE.
- diff bits of slices not yet processed are undefined while in RUN. Only the out_valid window is meaningful.
- Reset (rst=1 on an edge), from any state including mid-RUN:
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, diff=0, bout=0, zero=0, neg=0, ovf=0.
  - Carry and counter are cleared.
  - A partial operation is discarded, and no out_valid is produced for it.
  - in_valid is ignored during any cycle with rst=1.

## Timing
- Accept edge E0 (in_valid && in_ready sampled high).
- Slices 0..N-1 are processed on edges E1..EN. out_valid goes high after EN, so latency is N cycles (8 by default).
- Result handshake completes on the first edge with out_valid && out_ready. in_ready goes high after that edge.
- The earliest next accept is on the following edge. Back-to-back throughput is one operation per N+2 cycles with out_ready tied high.
- in_ready is 0 throughout RUN and DONE.
- Outputs are registered. Flags change only on the EN edge and on reset.

## Test plan
- Basic subtract:
  - Stimulus: a=0x00000005, b=0x00000003, bin=0.
  - Response: diff=0x00000002; bout, zero, neg and ovf all 0.
  - out_valid high exactly 8 cycles after accept.
- Borrow through all slices:
  - Stimulus: a=0x00000000, b=0x00000001, bin=0.
  - Response: diff=0xFFFFFFFF, bout=1, neg=1, ovf=0, zero=0.
  - Also a=0x10000000, b=1: diff=0x0FFFFFFF, bout=0.
- Signed overflow:
  - Stimulus: a=0x80000000, b=0x00000001.
  - Response: diff=0x7FFFFFFF, ovf=1, bout=0, neg=0.
- Borrow-in and zero:
  - Stimulus: a=0x12345678, b=0x12345677, bin=1.
  - Response: diff=0x00000000, zero=1, bout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands during that window.
  - Response: diff and flags stay stable and in_ready stays 0; the new operands are not taken.
  - After out_ready=1, in_ready=1 on the next cycle, and a re-presented operation completes correctly.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle at the 4th RUN cycle.
  - Response: out_valid never rises for that operation; in_ready=1 and all outputs are 0 after the reset edge.
  - Next operation a=100, b=58 returns diff=42 after 8 cycles.
